// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with a double-buffered digit store.
// Shadow writes are copied to the active store only at a frame boundary, so a frame never tears.
module seg_scan_driver #(
    parameter int unsigned N_DIGITS       = 10,
    parameter int unsigned CLK_DIV        = 1000,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter int unsigned SEL_ACTIVE_LOW = 0,
    parameter int unsigned SEG_ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic [5:0]          wr_data,
    input  logic                commit_req,
    output logic                commit_ack,
    input  logic                blank_all,
    output logic [7:0]          segm,
    output logic [N_DIGITS-1:0] sel,
    output logic                frame_tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [5:0]          BLANK_ENTRY = 6'h20;
    localparam logic [N_DIGITS-1:0] SEL_OFF     = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]          SEG_OFF     = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [CW-1:0]       cnt;
    logic [DW-1:0]       digit;
    logic                pending;
    logic [5:0]          shadow [N_DIGITS];
    logic [5:0]          active [N_DIGITS];

    logic                slot_end;
    logic                boundary;
    logic                do_commit;
    logic                wr_hit;
    logic [N_DIGITS-1:0] sel_nxt;
    logic [7:0]          segm_nxt;

    // Entry -> active-high segments: [5] blanks the whole digit including dp
    function automatic logic [7:0] decode(input logic [5:0] entry);
        logic [6:0] seg7;
        case (entry[3:0])
            4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
        endcase
        return entry[5] ? 8'h00 : {entry[4], seg7};
    endfunction

    // Slot timing, commit decision and next output values
    always_comb begin
        sel_nxt   = '0;
        segm_nxt  = '0;
        slot_end  = (cnt == CW'(CLK_DIV - 1));
        boundary  = slot_end && (digit == DW'(N_DIGITS - 1));
        do_commit = boundary && (pending || commit_req);
        wr_hit    = wr_en && (32'(wr_addr) < N_DIGITS);
        if (cnt >= CW'(BLANK_CYCLES)) begin
            segm_nxt = decode(active[digit]);
            if (!blank_all) begin
                sel_nxt = N_DIGITS'(1) << digit;
            end
        end
        sel_nxt  = sel_nxt ^ SEL_OFF;
        segm_nxt = segm_nxt ^ SEG_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            digit      <= '0;
            pending    <= 1'b0;
            sel        <= SEL_OFF;
            segm       <= SEG_OFF;
            frame_tick <= 1'b0;
            commit_ack <= 1'b0;
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                shadow[i] <= BLANK_ENTRY;
                active[i] <= BLANK_ENTRY;
            end
        end else begin
            sel        <= sel_nxt;
            segm       <= segm_nxt;
            frame_tick <= boundary;
            commit_ack <= do_commit;
            pending    <= do_commit ? 1'b0 : (pending | commit_req);
            if (slot_end) begin
                cnt   <= '0;
                digit <= (digit == DW'(N_DIGITS - 1)) ? '0 : digit + DW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
            // Copy reads the pre-write shadow; a same-cycle write waits for a later commit
            if (do_commit) begin
                for (int i = 0; i < int'(N_DIGITS); i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_hit) begin
                shadow[DW'(wr_addr)] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random traffic checked against a
// frame-position model (cycle index -> slot/digit by arithmetic, buffers as plain arrays).
module tb_seg_scan_driver;

    localparam int N_DIGITS = 10;
    localparam int CLK_DIV  = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = N_DIGITS * CLK_DIV;
    localparam logic [6:0] HEX_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic                clk = 1'b0;
    logic                rst, wr_en, commit_req, blank_all;
    logic [3:0]          wr_addr;
    logic [5:0]          wr_data;
    logic                commit_ack, frame_tick;
    logic [7:0]          segm;
    logic [N_DIGITS-1:0] sel;
    logic [19:0]         obs;
    logic [19:0]         exp_vec;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    logic [5:0] m_sh  [N_DIGITS];
    logic [5:0] m_act [N_DIGITS];
    logic       m_pend;

    seg_scan_driver #(
        .N_DIGITS(N_DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK),
        .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit_req(commit_req), .commit_ack(commit_ack), .blank_all(blank_all),
        .segm(segm), .sel(sel), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;
    assign obs = {sel, segm, frame_tick, commit_ack};

    function automatic logic [7:0] ref_seg(input logic [5:0] e);
        return e[5] ? 8'h00 : {e[4], HEX_TAB[e[3:0]]};
    endfunction

    // Predict outputs for the coming edge from the model, advance the model, then clock
    task automatic step();
        int c, d;
        logic [3:0] d4;
        logic bnd, com;
        logic [N_DIGITS-1:0] es;
        logic [7:0] eg;
        if (rst) begin
            exp_vec = '0;
            t = 0;
            m_pend = 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                m_sh[i] = 6'h20;
                m_act[i] = 6'h20;
            end
        end else begin
            c   = t % CLK_DIV;
            d   = (t / CLK_DIV) % N_DIGITS;
            d4  = 4'(d);
            bnd = ((t % FRAME) == FRAME - 1);
            es  = (c < BLANK || blank_all) ? '0 : (N_DIGITS'(1) << d);
            eg  = (c < BLANK) ? 8'h00 : ref_seg(m_act[d4]);
            com = bnd && (m_pend || commit_req);
            exp_vec = {es, eg, bnd, com};
            if (com) begin
                m_act = m_sh;
                m_pend = 1'b0;
            end else if (commit_req) begin
                m_pend = 1'b1;
            end
            if (wr_en && int'(wr_addr) < N_DIGITS) m_sh[wr_addr] = wr_data;
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; commit_req = 1'b0; blank_all = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step(); total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL reset_hold got=%h exp=%h", obs, exp_vec); end
        end
        rst = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            step(); total++;
            if (obs !== exp_vec || segm !== 8'h00 || frame_tick !== (i == 0 ? 1'b0 : frame_tick)) begin
                bad++; $display("FAIL reset_frame i=%0d got=%h exp=%h", i, obs, exp_vec);
            end
        end
    endtask

    task automatic test_write_no_commit();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 6'h05;
        step(); total++;
        if (obs !== exp_vec) begin bad++; $display("FAIL wr_only got=%h exp=%h", obs, exp_vec); end
        idle_inputs();
        for (int i = 0; i < FRAME; i++) begin
            step(); total++;
            if (obs !== exp_vec || segm !== 8'h00) begin
                bad++; $display("FAIL no_commit_blank got=%h exp=%h", obs, exp_vec);
            end
        end
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        while (t % FRAME != 0) begin
            step(); total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL commit_wait got=%h exp=%h", obs, exp_vec); end
        end
        total++;
        if (commit_ack !== 1'b1 || frame_tick !== 1'b1) begin
            bad++; $display("FAIL commit_ack_tick got ack=%b tick=%b exp 1 1", commit_ack, frame_tick);
        end
        for (int i = 1; i <= 9; i++) begin
            step(); total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL slot0_model got=%h exp=%h", obs, exp_vec); end
            if (i >= 3 && i <= 8 && (sel !== 10'h001 || segm !== 8'h6D)) begin
                bad++; $display("FAIL slot0_digit5 sel=%h segm=%h exp 001 6d", sel, segm);
            end
        end
    endtask

    task automatic test_commit_hex();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 6'h1A; commit_req = 1'b1;
        step();
        idle_inputs();
        while (t % FRAME != 0) begin
            step(); total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL hex_wait got=%h exp=%h", obs, exp_vec); end
        end
        for (int k = 1; k <= FRAME; k++) begin
            step(); total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL hex_frame got=%h exp=%h", obs, exp_vec); end
            if (((k - 1) % CLK_DIV) < BLANK && sel !== '0) begin
                bad++; $display("FAIL blank_guard sel=%h exp 000", sel);
            end
            if ((k - 1) / CLK_DIV == 3 && ((k - 1) % CLK_DIV) >= BLANK && (sel !== 10'h008 || segm !== 8'hF7)) begin
                bad++; $display("FAIL slot3_hexA sel=%h segm=%h exp 008 f7", sel, segm);
            end
        end
    endtask

    task automatic test_bad_addr();
        int acks = 0;
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = 6'h08; commit_req = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(); total++;
            if (commit_ack) acks++;
            if (obs !== exp_vec) begin bad++; $display("FAIL bad_addr got=%h exp=%h", obs, exp_vec); end
        end
        total++;
        if (acks !== 1) begin bad++; $display("FAIL bad_addr_ack_count got=%0d exp=1", acks); end
    endtask

    task automatic test_boundary_write();
        while (t % FRAME != FRAME - 1) step();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 6'h09; commit_req = 1'b1;
        step();
        idle_inputs();
        total++;
        if (obs !== exp_vec || commit_ack !== 1'b1) begin
            bad++; $display("FAIL bnd_commit got=%h exp=%h", obs, exp_vec);
        end
        for (int i = 1; i <= 4; i++) step();
        total++;
        if (segm !== 8'h6D || sel !== 10'h001) begin
            bad++; $display("FAIL bnd_old_value sel=%h segm=%h exp 001 6d", sel, segm);
        end
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        while (t % FRAME != 4) begin
            step(); total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL bnd_second got=%h exp=%h", obs, exp_vec); end
        end
        total++;
        if (segm !== 8'h6F || sel !== 10'h001) begin
            bad++; $display("FAIL bnd_new_value sel=%h segm=%h exp 001 6f", sel, segm);
        end
    endtask

    task automatic test_reset_mid();
        while (t % FRAME != 5 * CLK_DIV + 4) step();
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        rst = 1'b1;
        step(); total++;
        if (sel !== '0 || commit_ack !== 1'b0 || obs !== exp_vec) begin
            bad++; $display("FAIL reset_mid sel=%h ack=%b exp 000 0", sel, commit_ack);
        end
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(); total++;
            if (obs !== exp_vec || segm !== 8'h00 || commit_ack !== 1'b0) begin
                bad++; $display("FAIL reset_mid_blank got=%h exp=%h", obs, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1200; i++) begin
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_addr    = 4'($urandom_range(0, 15));
            wr_data    = 6'($urandom);
            commit_req = ($urandom_range(0, 99) < 2);
            blank_all  = ($urandom_range(0, 9) == 0);
            step(); total++;
            if (obs !== exp_vec) begin bad++; $display("FAIL random i=%0d got=%h exp=%h", i, obs, exp_vec); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_no_commit();
        test_commit_hex();
        test_bad_addr();
        test_boundary_write();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
